// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes opcode/funct into ALU controls, extends immediates,
// and forwards EX/MEM and MEM/WB results onto the ALU operands after the register.
module id_ex_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 5,
  parameter bit          FWD_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [5:0]          in_opcode,
  input  logic [5:0]          in_funct,
  input  logic [REG_BITS-1:0] in_rs,
  input  logic [REG_BITS-1:0] in_rt,
  input  logic [REG_BITS-1:0] in_rd,
  input  logic [WIDTH-1:0]    in_rs_val,
  input  logic [WIDTH-1:0]    in_rt_val,
  input  logic [15:0]         in_imm,
  input  logic                stall,
  input  logic                flush,
  input  logic                exmem_regwrite,
  input  logic                memwb_regwrite,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]    exmem_result,
  input  logic [WIDTH-1:0]    memwb_result,
  output logic [WIDTH-1:0]    data_1,
  output logic [WIDTH-1:0]    data_2,
  output logic [3:0]          aluop,
  output logic                ex_valid,
  output logic                ex_regwrite,
  output logic [REG_BITS-1:0] ex_dest,
  output logic                ex_memread,
  output logic                ex_memwrite,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic                ex_branch,
  output logic                ex_illegal
);

  localparam int unsigned IMM_W = 16;
  localparam int unsigned EXT_W = WIDTH - IMM_W;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_NOR = 4'b0111,
    ALU_SLT = 4'b1010
  } aluop_e;

  typedef struct packed {
    logic                valid;
    aluop_e              aluop;
    logic                regwrite;
    logic [REG_BITS-1:0] dest;
    logic                memread;
    logic                memwrite;
    logic                branch;
    logic                illegal;
    logic                use_imm;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [WIDTH-1:0]    rs_val;
    logic [WIDTH-1:0]    rt_val;
    logic [WIDTH-1:0]    imm;
  } ex_reg_t;

  ex_reg_t dec_c;
  ex_reg_t ex_d;
  ex_reg_t ex_q;

  logic [WIDTH-1:0] imm_sext_c;
  logic [WIDTH-1:0] imm_zext_c;
  logic [WIDTH-1:0] rs_fwd_c;
  logic [WIDTH-1:0] rt_fwd_c;

  assign imm_sext_c = {{EXT_W{in_imm[IMM_W-1]}}, in_imm};
  assign imm_zext_c = {{EXT_W{1'b0}}, in_imm};

  // Instruction decode; an invalid ID slot decodes to an all-zero bubble.
  always_comb begin
    dec_c = '0;
    if (in_valid) begin
      dec_c.valid  = 1'b1;
      dec_c.rs     = in_rs;
      dec_c.rt     = in_rt;
      dec_c.rs_val = in_rs_val;
      dec_c.rt_val = in_rt_val;
      case (in_opcode)
        6'h00: begin
          dec_c.dest     = in_rd;
          dec_c.regwrite = 1'b1;
          case (in_funct)
            6'h20, 6'h21: dec_c.aluop = ALU_ADD;
            6'h22, 6'h23: dec_c.aluop = ALU_SUB;
            6'h24:        dec_c.aluop = ALU_AND;
            6'h25:        dec_c.aluop = ALU_OR;
            6'h27:        dec_c.aluop = ALU_NOR;
            6'h2A:        dec_c.aluop = ALU_SLT;
            default: begin
              dec_c.illegal  = 1'b1;
              dec_c.regwrite = 1'b0;
              dec_c.dest     = '0;
            end
          endcase
        end
        6'h08, 6'h09: begin
          dec_c.aluop = ALU_ADD; dec_c.dest = in_rt; dec_c.regwrite = 1'b1;
          dec_c.use_imm = 1'b1; dec_c.imm = imm_sext_c;
        end
        6'h0A: begin
          dec_c.aluop = ALU_SLT; dec_c.dest = in_rt; dec_c.regwrite = 1'b1;
          dec_c.use_imm = 1'b1; dec_c.imm = imm_sext_c;
        end
        6'h0C: begin
          dec_c.aluop = ALU_AND; dec_c.dest = in_rt; dec_c.regwrite = 1'b1;
          dec_c.use_imm = 1'b1; dec_c.imm = imm_zext_c;
        end
        6'h0D: begin
          dec_c.aluop = ALU_OR; dec_c.dest = in_rt; dec_c.regwrite = 1'b1;
          dec_c.use_imm = 1'b1; dec_c.imm = imm_zext_c;
        end
        6'h23: begin
          dec_c.aluop = ALU_ADD; dec_c.dest = in_rt; dec_c.regwrite = 1'b1;
          dec_c.memread = 1'b1; dec_c.use_imm = 1'b1; dec_c.imm = imm_sext_c;
        end
        6'h2B: begin
          dec_c.aluop = ALU_ADD; dec_c.dest = in_rt; dec_c.memwrite = 1'b1;
          dec_c.use_imm = 1'b1; dec_c.imm = imm_sext_c;
        end
        6'h04: begin
          dec_c.aluop = ALU_SUB; dec_c.dest = in_rt; dec_c.branch = 1'b1;
        end
        default: dec_c.illegal = 1'b1;
      endcase
      // r0 is hardwired; never report a write to it.
      if (dec_c.dest == '0) dec_c.regwrite = 1'b0;
    end
  end

  // Flush takes priority over stall.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d = dec_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarding after the register so held instructions see current producers.
  always_comb begin
    rs_fwd_c = ex_q.rs_val;
    rt_fwd_c = ex_q.rt_val;
    if (FWD_EN) begin
      if (ex_q.rs != '0) begin
        if (exmem_regwrite && (exmem_rd == ex_q.rs)) begin
          rs_fwd_c = exmem_result;
        end else if (memwb_regwrite && (memwb_rd == ex_q.rs)) begin
          rs_fwd_c = memwb_result;
        end
      end
      if (ex_q.rt != '0) begin
        if (exmem_regwrite && (exmem_rd == ex_q.rt)) begin
          rt_fwd_c = exmem_result;
        end else if (memwb_regwrite && (memwb_rd == ex_q.rt)) begin
          rt_fwd_c = memwb_result;
        end
      end
    end
  end

  assign data_1        = rs_fwd_c;
  assign data_2        = ex_q.use_imm ? ex_q.imm : rt_fwd_c;
  assign ex_store_data = rt_fwd_c;
  assign aluop         = ex_q.aluop;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_dest       = ex_q.dest;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_branch     = ex_q.branch;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push expected EX-side
// outputs; a negedge monitor pops and compares each one.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic        stall, flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] data_1, data_2;
  logic [3:0]  aluop;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;
  logic [4:0]  ex_dest;
  logic [31:0] ex_store_data;

  typedef struct {
    string       name;
    logic [110:0] vec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  id_ex_stage #(.WIDTH(32), .REG_BITS(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .data_1(data_1), .data_2(data_2), .aluop(aluop), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_dest(ex_dest), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsv, input logic [31:0] rtv, input logic [15:0] imm);
    in_valid = v; in_opcode = op; in_funct = fn;
    in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_val = rsv; in_rt_val = rtv; in_imm = imm;
  endtask

  task automatic set_fwd(input logic exrw, input logic [4:0] exrd, input logic [31:0] exres,
                         input logic wbrw, input logic [4:0] wbrd, input logic [31:0] wbres);
    exmem_regwrite = exrw; exmem_rd = exrd; exmem_result = exres;
    memwb_regwrite = wbrw; memwb_rd = wbrd; memwb_result = wbres;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [3:0] op, input logic rw,
                            input logic [4:0] dest, input logic mr, input logic mw,
                            input logic br, input logic ill, input logic [31:0] st);
    exp_t e;
    e.name = name;
    e.vec  = {v, d1, d2, op, rw, dest, mr, mw, br, ill, st};
    q.push_back(e);
  endtask

  task automatic expect_zero(input string name);
    expect_out(name, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic clk_edge();
    @(posedge clk); #1;
  endtask

  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  initial begin
    exp_t         e;
    logic [110:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {ex_valid, data_1, data_2, aluop, ex_regwrite, ex_dest, ex_memread,
               ex_memwrite, ex_branch, ex_illegal, ex_store_data};
        checks++;
        if (act === e.vec) begin
          passed++;
        end else begin
          $display("FAIL %s: got v=%b d1=%h d2=%h op=%b rw=%b dst=%0d mr=%b mw=%b br=%b ill=%b st=%h; want v=%b d1=%h d2=%h op=%b rw=%b dst=%0d mr=%b mw=%b br=%b ill=%b st=%h",
                   e.name, act[110], act[109:78], act[77:46], act[45:42], act[41], act[40:36],
                   act[35], act[34], act[33], act[32], act[31:0],
                   e.vec[110], e.vec[109:78], e.vec[77:46], e.vec[45:42], e.vec[41], e.vec[40:36],
                   e.vec[35], e.vec[34], e.vec[33], e.vec[32], e.vec[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_id(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    clk_edge(); expect_zero("reset"); to_neg();
    rst_n = 1'b1;

    drive_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
    clk_edge(); expect_out("add", 1, 32'd5, 32'd7, 4'b0000, 1, 5'd3, 0, 0, 0, 0, 32'd7); to_neg();

    drive_id(1'b1, 6'h0D, 6'h00, 5'd1, 5'd4, 5'd0, 32'd3, 32'h11, 16'h8001);
    clk_edge(); expect_out("ori_zext", 1, 32'd3, 32'h0000_8001, 4'b0101, 1, 5'd4, 0, 0, 0, 0, 32'h11); to_neg();

    drive_id(1'b1, 6'h0A, 6'h00, 5'd1, 5'd5, 5'd0, 32'd3, 32'd2, 16'hFFFF);
    clk_edge(); expect_out("slti_sext", 1, 32'd3, 32'hFFFF_FFFF, 4'b1010, 1, 5'd5, 0, 0, 0, 0, 32'd2); to_neg();

    drive_id(1'b1, 6'h00, 6'h22, 5'd2, 5'd8, 5'd7, 32'd1, 32'h10, 16'h0);
    clk_edge(); set_fwd(1'b1, 5'd2, 32'hAA, 1'b1, 5'd2, 32'hBB);
    expect_out("fwd_exmem_wins", 1, 32'hAA, 32'h10, 4'b0010, 1, 5'd7, 0, 0, 0, 0, 32'h10); to_neg();

    stall = 1'b1;
    drive_id(1'b1, 6'h00, 6'h24, 5'd9, 5'd9, 5'd9, 32'h999, 32'h999, 16'h0);
    clk_edge(); set_fwd(1'b0, 5'd2, 32'hAA, 1'b1, 5'd2, 32'hBB);
    expect_out("stall1_fwd_memwb", 1, 32'hBB, 32'h10, 4'b0010, 1, 5'd7, 0, 0, 0, 0, 32'h10); to_neg();

    drive_id(1'b1, 6'h0D, 6'h00, 5'd3, 5'd3, 5'd3, 32'h333, 32'h333, 16'h1234);
    clk_edge(); set_fwd(1'b1, 5'd8, 32'hDD, 1'b1, 5'd8, 32'hCC);
    expect_out("stall2_rt_fwd", 1, 32'd1, 32'hDD, 4'b0010, 1, 5'd7, 0, 0, 0, 0, 32'hDD); to_neg();
    stall = 1'b0;

    drive_id(1'b1, 6'h00, 6'h24, 5'd0, 5'd3, 5'd9, 32'h55, 32'hF0, 16'h0);
    clk_edge(); set_fwd(1'b1, 5'd0, 32'h123, 1'b1, 5'd0, 32'h456);
    expect_out("rs0_no_fwd", 1, 32'h55, 32'hF0, 4'b0100, 1, 5'd9, 0, 0, 0, 0, 32'hF0); to_neg();

    drive_id(1'b1, 6'h2B, 6'h00, 5'd1, 5'd6, 5'd0, 32'h100, 32'd9, 16'hFFFC);
    clk_edge(); set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h44);
    expect_out("sw_store_fwd", 1, 32'h100, 32'hFFFF_FFFC, 4'b0000, 0, 5'd6, 0, 1, 0, 0, 32'h44); to_neg();

    drive_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd10, 5'd0, 32'h200, 32'h0, 16'h0008);
    clk_edge(); set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_out("lw", 1, 32'h200, 32'h8, 4'b0000, 1, 5'd10, 1, 0, 0, 0, 32'h0); to_neg();

    drive_id(1'b1, 6'h04, 6'h00, 5'd3, 5'd4, 5'd0, 32'd7, 32'd7, 16'h0002);
    clk_edge(); expect_out("beq", 1, 32'd7, 32'd7, 4'b0010, 0, 5'd4, 0, 0, 1, 0, 32'd7); to_neg();

    stall = 1'b1; flush = 1'b1;
    drive_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
    clk_edge(); expect_zero("flush_beats_stall"); to_neg();
    stall = 1'b0; flush = 1'b0;

    drive_id(1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 16'h0);
    clk_edge(); expect_out("bad_funct", 1, 32'd5, 32'd6, 4'b0000, 0, 5'd0, 0, 0, 0, 1, 32'd6); to_neg();

    drive_id(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 16'h0);
    clk_edge(); expect_out("bad_opcode", 1, 32'd5, 32'd6, 4'b0000, 0, 5'd0, 0, 0, 0, 1, 32'd6); to_neg();

    drive_id(1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
    clk_edge(); expect_zero("in_valid_low_bubble"); to_neg();

    drive_id(1'b1, 6'h0D, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0001);
    clk_edge(); expect_out("dest0_no_write", 1, 32'h0, 32'h1, 4'b0101, 0, 5'd0, 0, 0, 0, 0, 32'h0); to_neg();

    drive_id(1'b1, 6'h00, 6'h27, 5'd1, 5'd2, 5'd11, 32'hF0F0, 32'h0F0F, 16'h0);
    clk_edge(); expect_out("nor", 1, 32'hF0F0, 32'h0F0F, 4'b0111, 1, 5'd11, 0, 0, 0, 0, 32'h0F0F); to_neg();

    drive_id(1'b1, 6'h00, 6'h2A, 5'd1, 5'd2, 5'd12, 32'd4, 32'd9, 16'h0);
    clk_edge(); expect_out("slt", 1, 32'd4, 32'd9, 4'b1010, 1, 5'd12, 0, 0, 0, 0, 32'd9); to_neg();

    drive_id(1'b1, 6'h00, 6'h25, 5'd1, 5'd2, 5'd13, 32'd4, 32'd9, 16'h0);
    clk_edge(); expect_out("or", 1, 32'd4, 32'd9, 4'b0101, 1, 5'd13, 0, 0, 0, 0, 32'd9); to_neg();

    drive_id(1'b1, 6'h00, 6'h23, 5'd1, 5'd2, 5'd14, 32'd4, 32'd9, 16'h0);
    clk_edge(); expect_out("subu", 1, 32'd4, 32'd9, 4'b0010, 1, 5'd14, 0, 0, 0, 0, 32'd9); to_neg();

    drive_id(1'b1, 6'h0C, 6'h00, 5'd1, 5'd13, 5'd0, 32'd1, 32'd2, 16'hFFFF);
    clk_edge(); expect_out("andi_zext", 1, 32'd1, 32'h0000_FFFF, 4'b0100, 1, 5'd13, 0, 0, 0, 0, 32'd2); to_neg();

    drive_id(1'b1, 6'h09, 6'h00, 5'd1, 5'd14, 5'd0, 32'd10, 32'd3, 16'hFFFF);
    clk_edge(); expect_out("addiu_sext", 1, 32'd10, 32'hFFFF_FFFF, 4'b0000, 1, 5'd14, 0, 0, 0, 0, 32'd3); to_neg();

    // Reset asserted between edges must clear the just-captured instruction.
    drive_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0);
    clk_edge(); rst_n = 1'b0; expect_zero("async_reset"); to_neg();
    rst_n = 1'b1;

    drive_id(1'b1, 6'h00, 6'h21, 5'd4, 5'd5, 5'd6, 32'd1, 32'd2, 16'h0);
    clk_edge(); expect_out("after_reset_addu", 1, 32'd1, 32'd2, 4'b0000, 1, 5'd6, 0, 0, 0, 0, 32'd2); to_neg();

    for (int i = 0; i < 10 && q.size() > 0; i++) to_neg();
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
